// File: rtl/eth_xcvr_link_mgr.sv
// Link supervisor for 10GBASE-R lanes. It synchronizes per-lane PHY status and
// retries RX datapath resets when lock is not acquired. It also debounces link-up and keeps saturating stats.

module eth_xcvr_link_lane #(
    parameter int LOCK_TIMEOUT    = 1000000,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int RESET_CYCLES    = 16,
    parameter int CNT_WIDTH       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 done_in,
    input  logic                 lock_in,
    input  logic                 ber_in,
    input  logic                 stat_clear,
    output logic                 gt_reset_rx_datapath,
    output logic                 link_up,
    output logic [CNT_WIDTH-1:0] timeout_count,
    output logic [CNT_WIDTH-1:0] link_down_count
);

    // A limit of 1 still needs a 1-bit counter that only ever holds 0.
    localparam int TMR_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {ST_INIT, ST_ACQUIRE, ST_RESET, ST_UP} state_e;

    state_e               state_q, state_d;
    logic [1:0]           done_sync_q, lock_sync_q, ber_sync_q;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic [DEB_W-1:0]     deb_q, deb_d;
    logic [RST_W-1:0]     pulse_q, pulse_d;
    logic [CNT_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d, down_cnt_q, down_cnt_d;
    logic                 link_up_q, link_up_d, gt_rst_q, gt_rst_d;
    logic                 s_done, s_lock, s_ber, good, tmo_inc, down_inc;

    function automatic logic [CNT_WIDTH-1:0] sat_next(input logic [CNT_WIDTH-1:0] cnt,
                                                      input logic inc, input logic clr);
        if (clr) return inc ? CNT_WIDTH'(1) : '0;
        if (inc && cnt != '1) return cnt + CNT_WIDTH'(1);
        return cnt;
    endfunction

    assign s_done = done_sync_q[1];
    assign s_lock = lock_sync_q[1];
    assign s_ber  = ber_sync_q[1];
    assign good   = s_lock & ~s_ber;

    // Timers only advance in their own state and reload to 0 elsewhere, so every entry starts clean.
    always_comb begin
        state_d  = state_q;
        tmr_d    = '0;
        deb_d    = '0;
        pulse_d  = '0;
        tmo_inc  = 1'b0;
        down_inc = 1'b0;
        case (state_q)
            ST_INIT: if (s_done) state_d = ST_ACQUIRE;
            ST_ACQUIRE: begin
                tmr_d = tmr_q + TMR_W'(1);
                deb_d = good ? deb_q + DEB_W'(1) : '0;
                if (!s_done) begin
                    state_d = ST_INIT;
                end else if (good && deb_q == DEB_LAST) begin
                    state_d = ST_UP;
                end else if (tmr_q == TMR_LAST) begin
                    state_d = ST_RESET;
                    tmo_inc = 1'b1;
                end
            end
            ST_RESET: begin
                pulse_d = pulse_q + RST_W'(1);
                if (pulse_q == RST_LAST) state_d = ST_INIT;
            end
            ST_UP: begin
                if (!s_done || !good) begin
                    state_d  = s_done ? ST_ACQUIRE : ST_INIT;
                    down_inc = 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase
        link_up_d  = (state_d == ST_UP);
        gt_rst_d   = (state_d == ST_RESET);
        tmo_cnt_d  = sat_next(tmo_cnt_q, tmo_inc, stat_clear);
        down_cnt_d = sat_next(down_cnt_q, down_inc, stat_clear);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            done_sync_q <= '0;
            lock_sync_q <= '0;
            ber_sync_q  <= '0;
            tmr_q       <= '0;
            deb_q       <= '0;
            pulse_q     <= '0;
            tmo_cnt_q   <= '0;
            down_cnt_q  <= '0;
            link_up_q   <= 1'b0;
            gt_rst_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_sync_q <= {done_sync_q[0], done_in};
            lock_sync_q <= {lock_sync_q[0], lock_in};
            ber_sync_q  <= {ber_sync_q[0], ber_in};
            tmr_q       <= tmr_d;
            deb_q       <= deb_d;
            pulse_q     <= pulse_d;
            tmo_cnt_q   <= tmo_cnt_d;
            down_cnt_q  <= down_cnt_d;
            link_up_q   <= link_up_d;
            gt_rst_q    <= gt_rst_d;
        end
    end

    assign gt_reset_rx_datapath = gt_rst_q;
    assign link_up              = link_up_q;
    assign timeout_count        = tmo_cnt_q;
    assign link_down_count      = down_cnt_q;

endmodule

module eth_xcvr_link_mgr #(
    parameter int CHANNELS        = 4,
    parameter int LOCK_TIMEOUT    = 1000000,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int RESET_CYCLES    = 16,
    parameter int CNT_WIDTH       = 8
) (
    input  logic                          xcvr_ctrl_clk,
    input  logic                          xcvr_ctrl_rst_n,
    input  logic [CHANNELS-1:0]           gt_reset_rx_done,
    input  logic [CHANNELS-1:0]           rx_block_lock,
    input  logic [CHANNELS-1:0]           rx_high_ber,
    input  logic                          stat_clear,
    output logic [CHANNELS-1:0]           gt_reset_rx_datapath,
    output logic [CHANNELS-1:0]           link_up,
    output logic                          all_link_up,
    output logic [CHANNELS*CNT_WIDTH-1:0] timeout_count,
    output logic [CHANNELS*CNT_WIDTH-1:0] link_down_count
);

    logic all_link_up_q, all_link_up_d;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        eth_xcvr_link_lane #(
            .LOCK_TIMEOUT   (LOCK_TIMEOUT),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_CYCLES   (RESET_CYCLES),
            .CNT_WIDTH      (CNT_WIDTH)
        ) u_lane (
            .clk                 (xcvr_ctrl_clk),
            .rst_n               (xcvr_ctrl_rst_n),
            .done_in             (gt_reset_rx_done[i]),
            .lock_in             (rx_block_lock[i]),
            .ber_in              (rx_high_ber[i]),
            .stat_clear          (stat_clear),
            .gt_reset_rx_datapath(gt_reset_rx_datapath[i]),
            .link_up             (link_up[i]),
            .timeout_count       (timeout_count[i*CNT_WIDTH +: CNT_WIDTH]),
            .link_down_count     (link_down_count[i*CNT_WIDTH +: CNT_WIDTH])
        );
    end

    always_comb all_link_up_d = &link_up;

    always_ff @(posedge xcvr_ctrl_clk) begin
        if (!xcvr_ctrl_rst_n) all_link_up_q <= 1'b0;
        else                  all_link_up_q <= all_link_up_d;
    end

    assign all_link_up = all_link_up_q;

endmodule

// File: tb/tb_eth_xcvr_link_mgr.sv
// Bench for eth_xcvr_link_mgr: directed scenarios plus random traffic, scored
// every cycle against a behavioural lane model kept in the bench.

module tb_eth_xcvr_link_mgr;

    localparam int CH   = 2;
    localparam int LT   = 50;
    localparam int DEB  = 8;
    localparam int RC   = 4;
    localparam int CW   = 2;
    localparam int MAXC = (1 << CW) - 1;

    localparam int M_IDLE = 0, M_HUNT = 1, M_RETRY = 2, M_LINKED = 3;

    typedef struct packed {
        logic [CH-1:0]    gt;
        logic [CH-1:0]    lu;
        logic             all_up;
        logic [CH*CW-1:0] tc;
        logic [CH*CW-1:0] ldc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CH-1:0]    done, lock, ber;
    logic             stat_clear;
    logic [CH-1:0]    gt, lu;
    logic             all_up;
    logic [CH*CW-1:0] tc, ldc;

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc_n    = 0;
    exp_t exp_q[$];
    exp_t sb_e;

    // model state: lane phase, cycles spent hunting, current good run, pulse cycles left
    int            md[CH], age[CH], run[CH], left[CH], tcnt[CH], dcnt[CH];
    logic [CH-1:0] d_done[2], d_lock[2], d_ber[2];
    logic [CH-1:0] prev_lu;

    eth_xcvr_link_mgr #(
        .CHANNELS(CH), .LOCK_TIMEOUT(LT), .DEBOUNCE_CYCLES(DEB),
        .RESET_CYCLES(RC), .CNT_WIDTH(CW)
    ) dut (
        .xcvr_ctrl_clk       (clk),
        .xcvr_ctrl_rst_n     (rst_n),
        .gt_reset_rx_done    (done),
        .rx_block_lock       (lock),
        .rx_high_ber         (ber),
        .stat_clear          (stat_clear),
        .gt_reset_rx_datapath(gt),
        .link_up             (lu),
        .all_link_up         (all_up),
        .timeout_count       (tc),
        .link_down_count     (ldc)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", nm, cyc_n, act, exp_v);
        end
    endtask

    function automatic int sat_upd(input int c, input bit inc, input bit clr);
        if (clr) return inc ? 1 : 0;
        if (inc) return (c + 1 > MAXC) ? MAXC : c + 1;
        return c;
    endfunction

    // Predicts the outputs after the coming clock edge from the inputs driven now.
    task automatic model_step();
        exp_t e;
        bit   g, d, tinc, dinc;
        e = '0;
        if (!rst_n) begin
            for (int l = 0; l < CH; l++) begin
                md[l] = M_IDLE; age[l] = 0; run[l] = 0; left[l] = 0;
                tcnt[l] = 0; dcnt[l] = 0;
            end
            for (int j = 0; j < 2; j++) begin
                d_done[j] = '0; d_lock[j] = '0; d_ber[j] = '0;
            end
            prev_lu = '0;
        end else begin
            e.all_up = &prev_lu;
            for (int l = 0; l < CH; l++) begin
                g = d_lock[1][l] && !d_ber[1][l];
                d = d_done[1][l];
                tinc = 0; dinc = 0;
                case (md[l])
                    M_IDLE: if (d) begin md[l] = M_HUNT; age[l] = 0; run[l] = 0; end
                    M_HUNT: begin
                        if (!d) md[l] = M_IDLE;
                        else begin
                            run[l] = g ? run[l] + 1 : 0;
                            if (g && run[l] >= DEB) md[l] = M_LINKED;
                            else if (age[l] + 1 >= LT) begin
                                md[l] = M_RETRY; left[l] = RC; tinc = 1;
                            end else age[l]++;
                        end
                    end
                    M_RETRY: begin
                        left[l]--;
                        if (left[l] == 0) md[l] = M_IDLE;
                    end
                    default: begin
                        if (!d) begin md[l] = M_IDLE; dinc = 1; end
                        else if (!g) begin md[l] = M_HUNT; age[l] = 0; run[l] = 0; dinc = 1; end
                    end
                endcase
                tcnt[l] = sat_upd(tcnt[l], tinc, stat_clear);
                dcnt[l] = sat_upd(dcnt[l], dinc, stat_clear);
                e.lu[l] = (md[l] == M_LINKED);
                e.gt[l] = (md[l] == M_RETRY);
                e.tc[l*CW +: CW]  = CW'(tcnt[l]);
                e.ldc[l*CW +: CW] = CW'(dcnt[l]);
            end
            prev_lu = e.lu;
            d_done[1] = d_done[0]; d_lock[1] = d_lock[0]; d_ber[1] = d_ber[0];
            d_done[0] = done;      d_lock[0] = lock;      d_ber[0] = ber;
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            sb_e = exp_q.pop_front();
            cmp("sb_gt_reset", 32'(gt), 32'(sb_e.gt));
            cmp("sb_link_up", 32'(lu), 32'(sb_e.lu));
            cmp("sb_all_link_up", 32'(all_up), 32'(sb_e.all_up));
            cmp("sb_timeout_count", 32'(tc), 32'(sb_e.tc));
            cmp("sb_link_down_count", 32'(ldc), 32'(sb_e.ldc));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise, width, found;
        int pct[CH];
        rst_n = 1'b0; done = '0; lock = '0; ber = '0; stat_clear = 1'b0;
        @(negedge clk);

        // reset, then idle with no done
        repeat (5) cyc();
        cmp("rst_link_up", 32'(lu), 0);
        cmp("rst_gt_reset", 32'(gt), 0);
        cmp("rst_counts", 32'({tc, ldc}), 0);
        rst_n = 1'b1;
        repeat (100) cyc();
        cmp("idle_link_up", 32'(lu), 0);
        cmp("idle_gt_reset", 32'(gt), 0);
        cmp("idle_all_up", 32'(all_up), 0);

        // clean bring-up: 2 sync + 1 INIT exit + 8 debounce
        done[0] = 1'b1; lock[0] = 1'b1;
        repeat (10) cyc();
        cmp("up0_early", 32'(lu[0]), 0);
        cyc();
        cmp("up0_at_11", 32'(lu[0]), 1);
        cmp("all_lane1_init", 32'(all_up), 0);
        done[1] = 1'b1; lock[1] = 1'b1;
        repeat (11) cyc();
        cmp("up1_at_11", 32'(lu[1]), 1);
        cmp("all_same_cycle", 32'(all_up), 0);
        cyc();
        cmp("all_up_late", 32'(all_up), 1);

        // lane1 loses lock: leaves UP at 3, times out after 50 hunting cycles
        lock[1] = 1'b0; rise = 0; width = 0;
        for (int k = 1; k <= 60; k++) begin
            cyc();
            if (gt[1]) begin
                if (rise == 0) rise = k;
                width++;
            end
        end
        cmp("timeout_rise", 32'(rise), 53);
        cmp("pulse_width", 32'(width), RC);
        cmp("timeout_cnt1", 32'(tc[3:2]), 1);
        repeat (160) cyc();
        cmp("timeout_sat", 32'(tc[3:2]), 3);

        // debounce glitch on lane0: lock low seen while debounce count is 5
        done[0] = 1'b0;
        repeat (6) cyc();
        done[0] = 1'b1; rise = 0;
        for (int k = 1; k <= 25; k++) begin
            cyc();
            if (lu[0] && rise == 0) rise = k;
            if (k == 6) lock[0] = 1'b0;
            if (k == 7) lock[0] = 1'b1;
        end
        cmp("glitch_rise", 32'(rise), 17);

        // link loss via one-cycle high BER
        stat_clear = 1'b1; cyc(); stat_clear = 1'b0;
        ber[0] = 1'b1; cyc(); ber[0] = 1'b0;
        cyc();
        cmp("loss_hold", 32'(lu[0]), 1);
        cyc();
        cmp("loss_fall", 32'(lu[0]), 0);
        cmp("loss_cnt", 32'(ldc[1:0]), 1);
        repeat (15) cyc();
        cmp("reup", 32'(lu[0]), 1);
        ber[0] = 1'b1; cyc(); ber[0] = 1'b0;
        cyc();
        stat_clear = 1'b1; cyc(); stat_clear = 1'b0;
        cmp("loss2_fall", 32'(lu[0]), 0);
        cmp("clear_with_inc", 32'(ldc[1:0]), 1);

        // reset in the second cycle of a lane1 datapath reset pulse
        for (int k = 0; k < 20 && gt[1]; k++) cyc();
        found = 0;
        for (int k = 0; k < 120 && found == 0; k++) begin
            cyc();
            if (gt[1]) found = 1;
        end
        cmp("pulse_found", 32'(found), 1);
        cyc();
        cmp("pulse_cycle2", 32'(gt[1]), 1);
        rst_n = 1'b0;
        cyc();
        cmp("midrst_gt", 32'(gt), 0);
        cmp("midrst_link_up", 32'(lu), 0);
        cmp("midrst_counts", 32'({tc, ldc}), 0);
        rst_n = 1'b1;

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int l = 0; l < CH; l++) begin
                if (c % 150 == 0) begin
                    case ($urandom_range(0, 2))
                        0:       pct[l] = 0;
                        1:       pct[l] = 90;
                        default: pct[l] = 100;
                    endcase
                end
                if ($urandom_range(0, 99) < (done[l] ? 1 : 10)) done[l] = ~done[l];
                lock[l] = ($urandom_range(0, 99) < pct[l]);
                ber[l]  = ($urandom_range(0, 199) == 0);
            end
            stat_clear = ($urandom_range(0, 99) == 0);
            rst_n      = ($urandom_range(0, 999) != 0);
            cyc();
        end
        rst_n = 1'b1; stat_clear = 1'b0;
        cyc();
        cmp("sb_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
